// File: rtl/sal_pb_refresh_sched_pkg.sv
// Shared constants and types for the SAL per-bank refresh scheduler.
package sal_pb_refresh_sched_pkg;
  localparam int NUM_BANKS_DEF    = 16;
  localparam int MAX_POSTPONE_DEF = 8;

  typedef enum logic [1:0] {IDLE, REQ, GAP} ref_fsm_t;
endpackage

// File: rtl/sal_pb_refresh_sched_timer.sv
// Refresh interval timer: free-running up-counter that pulses tick_o once per trefi_i cycles.
module sal_ref_interval_timer #(
  parameter int TREFI_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [TREFI_W-1:0] trefi_i,
  output logic               tick_o
);
  logic [TREFI_W-1:0] count;
  logic               run;

  // >= rather than == so a shrinking trefi_i takes effect without waiting for a wrap
  assign run    = enable_i && (trefi_i != '0);
  assign tick_o = run && (count >= trefi_i - TREFI_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (run) count <= tick_o ? '0 : count + TREFI_W'(1);
  end
endmodule

// File: rtl/sal_pb_refresh_sched.sv
// Per-bank refresh scheduler: accrues refresh debt from the interval timer and
// hands it out round-robin over per-bank ref_req/ref_gnt handshakes.
module sal_pb_refresh_sched
  import sal_pb_refresh_sched_pkg::*;
#(
  parameter int NUM_BANKS    = NUM_BANKS_DEF,
  parameter int TREFI_W      = 16,
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEF,
  localparam int DW = $clog2(MAX_POSTPONE + 1),
  localparam int PW = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [TREFI_W-1:0]   trefi_i,
  output logic [NUM_BANKS-1:0] ref_req_o,
  input  logic [NUM_BANKS-1:0] ref_gnt_i,
  output logic                 urgent_o,
  output logic [DW-1:0]        debt_o,
  output logic                 overflow_o,
  output logic                 idle_o
);
  ref_fsm_t      state, state_nx;
  logic [PW-1:0] ptr, ptr_nx;
  logic [DW-1:0] debt, debt_nx;
  logic          tick, grant_ok, ovf_set;

  sal_ref_interval_timer #(.TREFI_W(TREFI_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable_i),
    .trefi_i  (trefi_i),
    .tick_o   (tick)
  );

  assign grant_ok = (state == REQ) && ref_gnt_i[ptr];
  assign debt_o   = debt;

  always_comb begin
    debt_nx  = debt;
    ovf_set  = 1'b0;
    state_nx = state;
    ptr_nx   = ptr;
    // A tick arriving at full debt is dropped and remembered in overflow_o
    if (tick && !grant_ok) begin
      if (debt == DW'(MAX_POSTPONE)) ovf_set = 1'b1;
      else                           debt_nx = debt + DW'(1);
    end else if (grant_ok && !tick) begin
      debt_nx = debt - DW'(1);
    end
    case (state)
      IDLE: if (debt != '0) state_nx = REQ;
      REQ: if (grant_ok) begin
        state_nx = GAP;
        ptr_nx   = (ptr == PW'(NUM_BANKS - 1)) ? '0 : ptr + PW'(1);
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      debt       <= '0;
      ref_req_o  <= '0;
      urgent_o   <= 1'b0;
      overflow_o <= 1'b0;
      idle_o     <= 1'b1;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      debt       <= debt_nx;
      ref_req_o  <= (state_nx == REQ) ? (NUM_BANKS'(1) << ptr_nx) : '0;
      urgent_o   <= (debt_nx >= DW'(MAX_POSTPONE));
      overflow_o <= overflow_o | ovf_set;
      idle_o     <= (debt_nx == '0) && (state_nx == IDLE);
    end
  end
endmodule

// File: tb/tb_sal_pb_refresh_sched.sv
// Bench for sal_pb_refresh_sched: scenario tasks plus randomized traffic against a behavioural model.
module tb_sal_pb_refresh_sched;
  localparam int NB   = 16;
  localparam int TW   = 16;
  localparam int MAXP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable_i = 1'b0;
  logic [TW-1:0] trefi_i = '0;
  logic [NB-1:0] ref_gnt_i = '0;
  logic [NB-1:0] ref_req_o;
  logic          urgent_o, overflow_o, idle_o;
  logic [3:0]    debt_o;

  int tests = 0;
  int fails = 0;

  // Model: timer count, owed refreshes, sticky loss flag, outstanding request,
  // bank pointer and a one-edge cool-down after each accepted grant.
  int m_cnt, m_debt, m_ptr;
  bit m_ovf, m_req, m_cool;

  sal_pb_refresh_sched #(.NUM_BANKS(NB), .TREFI_W(TW), .MAX_POSTPONE(MAXP)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .trefi_i(trefi_i),
    .ref_req_o(ref_req_o), .ref_gnt_i(ref_gnt_i), .urgent_o(urgent_o),
    .debt_o(debt_o), .overflow_o(overflow_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] exp_req();
    return m_req ? (NB'(1) << m_ptr) : '0;
  endfunction

  function automatic bit exp_idle();
    return (m_debt == 0) && !m_req && !m_cool;
  endfunction

  function automatic bit will_tick(input logic en, input logic [TW-1:0] tr);
    return en && (tr != 0) && (m_cnt >= int'(tr) - 1);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_debt = 0; m_ptr = 0; m_ovf = 0; m_req = 0; m_cool = 0;
  endtask

  // Called at a negedge; applies inputs across one posedge and returns at the next negedge.
  task automatic step(input logic en, input logic [TW-1:0] tr, input logic [NB-1:0] g);
    bit tk, gok;
    int dold;
    enable_i = en; trefi_i = tr; ref_gnt_i = g;
    tk = will_tick(en, tr);
    @(posedge clk);
    if (en && tr != 0) m_cnt = tk ? 0 : m_cnt + 1;
    gok  = m_req && g[m_ptr];
    dold = m_debt;
    if (tk && !gok) begin
      if (m_debt == MAXP) m_ovf = 1;
      else                m_debt++;
    end else if (gok && !tk) m_debt--;
    if (m_req) begin
      if (gok) begin m_req = 0; m_ptr = (m_ptr + 1) % NB; m_cool = 1; end
    end else if (m_cool) m_cool = 0;
    else if (dold != 0) m_req = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable_i = 1'b0; trefi_i = '0; ref_gnt_i = '0;
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    tests++;
    if (ref_req_o !== '0 || debt_o !== 4'd0 || urgent_o !== 1'b0 || overflow_o !== 1'b0 || idle_o !== 1'b1) begin
      fails++;
      $display("FAIL reset: req=%h debt=%0d urg=%b ovf=%b idle=%b, expected 0/0/0/0/1",
               ref_req_o, debt_o, urgent_o, overflow_o, idle_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [NB-1:0] seq[$];
    logic [NB-1:0] prev = '0;
    int first = -1;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      step(1'b1, TW'(10), exp_req());
      tests++;
      if (ref_req_o !== exp_req() || debt_o !== 4'(m_debt)) begin
        fails++;
        $display("FAIL rr_cycle%0d: req=%h debt=%0d, expected req=%h debt=%0d", i, ref_req_o, debt_o, exp_req(), m_debt);
      end
      if (ref_req_o != '0 && prev == '0) begin
        seq.push_back(ref_req_o);
        if (first < 0) first = i;
      end
      prev = ref_req_o;
    end
    tests++;
    if (first != 11) begin fails++; $display("FAIL rr_first_latency: got %0d, expected 11", first); end
    tests++;
    if (seq.size() < 17 || seq[0] !== 16'h0001 || seq[1] !== 16'h0002 || seq[15] !== 16'h8000 || seq[16] !== 16'h0001) begin
      fails++;
      $display("FAIL rr_sequence: %0d requests, expected 0001,0002..8000,0001 order", seq.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 36; i++) begin
      step(1'b1, TW'(4), '0);
      tests++;
      if (debt_o !== 4'(m_debt) || urgent_o !== (m_debt >= MAXP) || overflow_o !== m_ovf) begin
        fails++;
        $display("FAIL ovf_cycle%0d: debt=%0d urg=%b ovf=%b, expected %0d/%b/%b", i, debt_o, urgent_o, overflow_o, m_debt, m_debt >= MAXP, m_ovf);
      end
    end
    tests++;
    if (debt_o !== 4'd8 || urgent_o !== 1'b1 || overflow_o !== 1'b1 || ref_req_o !== 16'h0001) begin
      fails++;
      $display("FAIL ovf_final: debt=%0d urg=%b ovf=%b req=%h, expected 8/1/1/0001", debt_o, urgent_o, overflow_o, ref_req_o);
    end
  endtask

  task automatic test_tick_and_grant();
    int n = 0;
    do_reset();
    while (!(m_debt == 3 && m_req) && n < 50) begin step(1'b1, TW'(4), '0); n++; end
    while (!will_tick(1'b1, TW'(4)) && n < 50) begin step(1'b1, TW'(4), '0); n++; end
    tests++;
    if (n >= 50) begin fails++; $display("FAIL tg_setup: timed out, got %0d cycles, expected < 50", n); end
    step(1'b1, TW'(4), exp_req());
    tests++;
    if (debt_o !== 4'd3 || ref_req_o !== '0) begin
      fails++; $display("FAIL tg_debt: debt=%0d req=%h, expected 3/0000", debt_o, ref_req_o);
    end
    step(1'b1, TW'(4), '0);
    tests++;
    if (ref_req_o !== '0) begin fails++; $display("FAIL tg_gap: req=%h, expected 0000", ref_req_o); end
    step(1'b1, TW'(4), '0);
    tests++;
    if (ref_req_o !== 16'h0002 || debt_o !== 4'd3) begin
      fails++; $display("FAIL tg_next: req=%h debt=%0d, expected 0002/3", ref_req_o, debt_o);
    end
  endtask

  task automatic test_spurious_grant();
    logic [NB-1:0] held;
    int dh, n = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, '0, '1);
      tests++;
      if (idle_o !== 1'b1 || debt_o !== 4'd0 || ref_req_o !== '0) begin
        fails++; $display("FAIL sp_idle%0d: idle=%b debt=%0d req=%h, expected 1/0/0000", i, idle_o, debt_o, ref_req_o);
      end
    end
    while (!m_req && n < 20) begin step(1'b1, TW'(3), '0); n++; end
    held = ref_req_o; dh = m_debt;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, '0, ~exp_req());
      tests++;
      if (ref_req_o !== held || ref_req_o !== exp_req() || debt_o !== 4'(dh)) begin
        fails++; $display("FAIL sp_other%0d: req=%h debt=%0d, expected %h/%0d", i, ref_req_o, debt_o, held, dh);
      end
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    do_reset();
    while (!m_req && n < 20) begin step(1'b1, TW'(5), '0); n++; end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, TW'(5), '0);
      tests++;
      if (ref_req_o !== 16'h0001 || debt_o !== 4'(m_debt)) begin
        fails++; $display("FAIL en_hold%0d: req=%h debt=%0d, expected 0001/%0d", i, ref_req_o, debt_o, m_debt);
      end
    end
    step(1'b0, TW'(5), exp_req());
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (ref_req_o !== exp_req() || debt_o !== 4'(m_debt) || idle_o !== exp_idle()) begin
        fails++; $display("FAIL en_resume%0d: req=%h debt=%0d idle=%b, expected %h/%0d/%b", i, ref_req_o, debt_o, idle_o, exp_req(), m_debt, exp_idle());
      end
      step(i >= 3, TW'(5), '0);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    while (m_debt != 5 && n < 40) begin step(1'b1, TW'(2), '0); n++; end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (ref_req_o !== '0 || debt_o !== 4'd0 || idle_o !== 1'b1 || urgent_o !== 1'b0) begin
      fails++; $display("FAIL arst_now: req=%h debt=%0d idle=%b urg=%b, expected 0000/0/1/0", ref_req_o, debt_o, idle_o, urgent_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n = 0;
    while (!m_req && n < 20) begin step(1'b1, TW'(2), '0); n++; end
    tests++;
    if (ref_req_o !== 16'h0001) begin fails++; $display("FAIL arst_ptr: req=%h, expected 0001", ref_req_o); end
  endtask

  task automatic test_random();
    logic [TW-1:0] tr = TW'(3);
    logic          en;
    logic [NB-1:0] g;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) tr = TW'($urandom_range(0, 7));
      en = ($urandom_range(0, 9) != 0);
      g  = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
      if (m_req && $urandom_range(0, 9) < 4) g = g | exp_req();
      step(en, tr, g);
      tests++;
      if (ref_req_o !== exp_req() || debt_o !== 4'(m_debt) || urgent_o !== (m_debt >= MAXP) ||
          overflow_o !== m_ovf || idle_o !== exp_idle()) begin
        fails++;
        $display("FAIL rand%0d: req=%h debt=%0d urg=%b ovf=%b idle=%b, expected %h/%0d/%b/%b/%b", i,
                 ref_req_o, debt_o, urgent_o, overflow_o, idle_o, exp_req(), m_debt, m_debt >= MAXP, m_ovf, exp_idle());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_overflow();
    test_tick_and_grant();
    test_spurious_grant();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
